rf80386_icache: RTL and testbench

Two-bank, direct-mapped instruction cache feeding the rf80386 core. It takes the core's linear fetch address (`csip`) and returns a 128-bit, byte-aligned instruction bundle starting at that address, plus `ihit`. On a miss it fills from the FTA 128-bit bus. It sits directly upstream of the core's `ibundle`/`ihit` inputs and shares the core's FTA master channel conventions.

---
 rtl/fta_bus_pkg.sv | 38 +++
 rtl/rf80386_pkg.sv | 20 ++
 rtl/rf80386_icache_bank.sv | 56 +++++
 rtl/rf80386_icache.sv | 199 +++++++++++++++++++
 tb/tb_rf80386_icache.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fta_bus_pkg.sv
// FTA 128-bit bus command types shared by FTA masters and slaves.
//   fta_cmd_request128_t  : master -> slave command (cmd, cyc/stb/we, sel, adr, dat, tid)
//   fta_cmd_response128_t : slave -> master response (tid, ack/rty/err, adr, dat)
package fta_bus_pkg;

   typedef enum logic [4:0] {
      CMD_NONE  = 5'd0,
      CMD_LOAD  = 5'd1,
      CMD_STORE = 5'd2
   } fta_cmd_t;

   typedef struct packed {
      logic [5:0] core;
      logic [2:0] channel;
      logic [3:0] tranid;
   } fta_tranid_t;

   typedef struct packed {
      fta_cmd_t     cmd;
      logic         cyc;
      logic         stb;
      logic         we;
      logic [15:0]  sel;
      logic [31:0]  adr;
      logic [127:0] dat;
      fta_tranid_t  tid;
   } fta_cmd_request128_t;

   typedef struct packed {
      fta_tranid_t  tid;
      logic         ack;
      logic         rty;
      logic         err;
      logic [31:0]  adr;
      logic [127:0] dat;
   } fta_cmd_response128_t;

endpackage

// File: rtl/rf80386_pkg.sv
// rf80386 core-level shared definitions used by the instruction cache.
//   icache_state_t  : fill FSM state encoding
//   ICACHE_RTY_WAIT : cycles spent backing off after a bus retry
//   icache_tid_next : transaction id sequence 1..15, never 0
package rf80386_pkg;

   typedef enum logic [1:0] {
      IC_IDLE,
      IC_REQ,
      IC_WAIT,
      IC_RTY
   } icache_state_t;

   localparam int ICACHE_RTY_WAIT = 8;

   function automatic logic [3:0] icache_tid_next(input logic [3:0] t);
      return (t == 4'd15) ? 4'd1 : t + 4'd1;
   endfunction

endpackage

// File: rtl/rf80386_icache_bank.sv
// One bank of the instruction cache: tag/data/valid array.
//   clk_i, rst_ni  : clock, async active-low reset (valid bits only)
//   clr_i          : clear every valid bit on this edge (wins over a write)
//   we_i           : write tag/data at widx_i, valid bit <= wvalid_i
//   ridx_i         : async read index -> rvalid_o, rtag_o, rdat_o
module rf80386_icache_bank #(
   parameter int DEPTH = 32,
   parameter int TAG_W = 22,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               clr_i,
   input  logic               we_i,
   input  logic               wvalid_i,
   input  logic [IDX_W-1:0]   widx_i,
   input  logic [TAG_W-1:0]   wtag_i,
   input  logic [127:0]       wdat_i,
   input  logic [IDX_W-1:0]   ridx_i,
   output logic               rvalid_o,
   output logic [TAG_W-1:0]   rtag_o,
   output logic [127:0]       rdat_o
);

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [TAG_W-1:0] tag_mem [DEPTH];
   logic [127:0]     dat_mem [DEPTH];

   always_comb begin
      valid_d = valid_q;
      if (we_i)
         valid_d[widx_i] = wvalid_i;
      if (clr_i)
         valid_d = '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         valid_q <= '0;
      else
         valid_q <= valid_d;
   end

   // Tag/data carry no reset: they are meaningless while the valid bit is 0.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         tag_mem[widx_i] <= wtag_i;
         dat_mem[widx_i] <= wdat_i;
      end
   end

   assign rvalid_o = valid_q[ridx_i];
   assign rtag_o   = tag_mem[ridx_i];
   assign rdat_o   = dat_mem[ridx_i];

endmodule

// File: rtl/rf80386_icache.sv
// Two-bank direct-mapped instruction cache for the rf80386 core.
// Returns the 16 bytes starting at csip_i (which may straddle two lines)
// combinationally on a hit; fills missing lines one at a time over FTA.
//   clk_i, rst_ni : clock, async active-low reset
//   csip_i        : linear fetch byte address
//   invall_i      : invalidate all lines (pulse)
//   ibundle_o     : bytes csip_i..csip_i+15, byte 0 in [7:0]
//   ihit_o        : ibundle_o valid this cycle
//   ftam_req/resp : FTA 128-bit master channel
module rf80386_icache
   import fta_bus_pkg::*;
   import rf80386_pkg::*;
#(
   parameter int         LINES  = 64,
   parameter logic [5:0] CORENO = 6'd1,
   parameter logic [2:0] CID    = 3'd2,
   parameter int         TMO    = 63
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [31:0]          csip_i,
   input  logic                 invall_i,
   output logic [127:0]         ibundle_o,
   output logic                 ihit_o,
   output fta_cmd_request128_t  ftam_req,
   input  fta_cmd_response128_t ftam_resp
);

   localparam int LW    = $clog2(LINES);
   localparam int IDX_W = LW - 1;
   localparam int TAG_W = 28 - LW;
   localparam int TMO_W = (TMO < 2) ? 1 : $clog2(TMO + 1);
   localparam int RTY_W = $clog2(ICACHE_RTY_WAIT);

   icache_state_t       state_q, state_d;
   logic [27:0]         fadr_q, fadr_d;
   logic [3:0]          tid_q, tid_d;
   logic                kill_q, kill_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic [RTY_W-1:0]    rty_q, rty_d;
   fta_cmd_request128_t req_q, req_d;

   logic [27:0]      la, la1;
   logic [IDX_W-1:0] ev_idx, od_idx;
   logic [TAG_W-1:0] ev_tag_exp, od_tag_exp, ev_tag, od_tag;
   logic             ev_v, od_v, hit_ev, hit_od, hit_lo;
   logic [127:0]     ev_dat, od_dat, line_lo, line_hi;
   logic [255:0]     pair;
   logic             ack_ok, rty_ok, fill_we, fill_valid;
   logic             unused_resp;

   assign la  = csip_i[31:4];
   assign la1 = la + 28'd1;

   // la and la+1 always differ in bit 0. The odd line of the pair shares
   // la's index/tag in both cases; the even line is la+1 only when la is odd.
   assign od_idx     = la[LW-1:1];
   assign od_tag_exp = la[27:LW];
   assign ev_idx     = la[0] ? la1[LW-1:1] : la[LW-1:1];
   assign ev_tag_exp = la[0] ? la1[27:LW]  : la[27:LW];

   assign fill_valid = !kill_q && !invall_i;

   rf80386_icache_bank #(.DEPTH(LINES/2), .TAG_W(TAG_W)) u_even (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clr_i    (invall_i),
      .we_i     (fill_we && !fadr_q[0]),
      .wvalid_i (fill_valid),
      .widx_i   (fadr_q[LW-1:1]),
      .wtag_i   (fadr_q[27:LW]),
      .wdat_i   (ftam_resp.dat),
      .ridx_i   (ev_idx),
      .rvalid_o (ev_v),
      .rtag_o   (ev_tag),
      .rdat_o   (ev_dat)
   );

   rf80386_icache_bank #(.DEPTH(LINES/2), .TAG_W(TAG_W)) u_odd (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clr_i    (invall_i),
      .we_i     (fill_we && fadr_q[0]),
      .wvalid_i (fill_valid),
      .widx_i   (fadr_q[LW-1:1]),
      .wtag_i   (fadr_q[27:LW]),
      .wdat_i   (ftam_resp.dat),
      .ridx_i   (od_idx),
      .rvalid_o (od_v),
      .rtag_o   (od_tag),
      .rdat_o   (od_dat)
   );

   assign hit_ev  = ev_v && (ev_tag == ev_tag_exp);
   assign hit_od  = od_v && (od_tag == od_tag_exp);
   assign hit_lo  = la[0] ? hit_od : hit_ev;
   assign line_lo = la[0] ? od_dat : ev_dat;
   assign line_hi = la[0] ? ev_dat : od_dat;
   assign pair    = {line_hi, line_lo};

   assign ihit_o    = hit_ev && hit_od && (state_q == IC_IDLE);
   assign ibundle_o = pair[{1'b0, csip_i[3:0], 3'd0} +: 128];

   assign ack_ok = ftam_resp.ack && (ftam_resp.tid.tranid == tid_q);
   assign rty_ok = ftam_resp.rty && (ftam_resp.tid.tranid == tid_q);

   assign unused_resp = ^{ftam_resp.err, ftam_resp.adr,
                          ftam_resp.tid.core, ftam_resp.tid.channel};

   always_comb begin
      state_d = state_q;
      fadr_d  = fadr_q;
      tid_d   = tid_q;
      tmo_d   = tmo_q;
      rty_d   = rty_q;
      fill_we = 1'b0;
      case (state_q)
         IC_IDLE: begin
            if (!(hit_ev && hit_od)) begin
               fadr_d  = hit_lo ? la1 : la;
               state_d = IC_REQ;
            end
         end
         IC_REQ: begin
            tmo_d   = TMO_W'(TMO);
            state_d = IC_WAIT;
         end
         IC_WAIT: begin
            if (ack_ok) begin
               fill_we = 1'b1;
               tid_d   = icache_tid_next(tid_q);
               state_d = IC_IDLE;
            end else if (rty_ok) begin
               rty_d   = RTY_W'(ICACHE_RTY_WAIT - 1);
               state_d = IC_RTY;
            end else if (tmo_q <= TMO_W'(1)) begin
               // Give up on this tid; any ack that still arrives is stale.
               tid_d   = icache_tid_next(tid_q);
               state_d = IC_REQ;
            end else begin
               tmo_d = tmo_q - TMO_W'(1);
            end
         end
         IC_RTY: begin
            if (rty_q == '0)
               state_d = IC_REQ;
            else
               rty_d = rty_q - RTY_W'(1);
         end
         default: state_d = IC_IDLE;
      endcase

      // kill only matters for a fill already in flight; invall_i in IDLE
      // clears the arrays before any new fill starts.
      if (state_d == IC_IDLE)
         kill_d = 1'b0;
      else
         kill_d = kill_q || (invall_i && (state_q != IC_IDLE));

      // Request is registered and asserted exactly for the REQ cycle.
      req_d             = '0;
      req_d.cmd         = CMD_NONE;
      req_d.tid.core    = CORENO;
      req_d.tid.channel = CID;
      if (state_d == IC_REQ) begin
         req_d.cmd        = CMD_LOAD;
         req_d.cyc        = 1'b1;
         req_d.stb        = 1'b1;
         req_d.sel        = 16'hFFFF;
         req_d.adr        = {fadr_d, 4'h0};
         req_d.tid.tranid = tid_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q             <= IC_IDLE;
         fadr_q              <= '0;
         tid_q               <= 4'd1;
         kill_q              <= 1'b0;
         tmo_q               <= '0;
         rty_q               <= '0;
         req_q               <= '0;
         req_q.tid.core      <= CORENO;
         req_q.tid.channel   <= CID;
      end else begin
         state_q <= state_d;
         fadr_q  <= fadr_d;
         tid_q   <= tid_d;
         kill_q  <= kill_d;
         tmo_q   <= tmo_d;
         rty_q   <= rty_d;
         req_q   <= req_d;
      end
   end

   assign ftam_req = req_q;

endmodule

// File: tb/tb_rf80386_icache.sv
// Self-checking bench for rf80386_icache. The bench plays the FTA slave
// (line contents come from a fixed hash of the line address) and keeps a
// slot-based model of which line each direct-mapped slot holds.
module tb_rf80386_icache;
   import fta_bus_pkg::*;

   localparam int LINES = 64;
   localparam int TMO   = 63;

   logic                 clk = 1'b0;
   logic                 rst_ni;
   logic [31:0]          csip_i;
   logic                 invall_i;
   logic [127:0]         ibundle_o;
   logic                 ihit_o;
   fta_cmd_request128_t  ftam_req;
   fta_cmd_response128_t ftam_resp;

   rf80386_icache #(.LINES(LINES), .CORENO(6'd1), .CID(3'd2), .TMO(TMO)) dut (
      .clk_i     (clk),
      .rst_ni    (rst_ni),
      .csip_i    (csip_i),
      .invall_i  (invall_i),
      .ibundle_o (ibundle_o),
      .ihit_o    (ihit_o),
      .ftam_req  (ftam_req),
      .ftam_resp (ftam_resp)
   );

   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   int nerr = 0;
   int nchk = 0;
   logic [27:0] m_tag [LINES];
   bit          m_v   [LINES];
   logic [3:0]  exp_tid;
   logic [3:0]  last_tid = 4'd0;
   bit          saw_wrap = 1'b0;
   fta_cmd_request128_t rst_req;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] nx(input logic [3:0] t);
      return (t == 4'd15) ? 4'd1 : t + 4'd1;
   endfunction

   function automatic logic [127:0] mem_line(input logic [27:0] l);
      logic [127:0] r;
      logic [31:0]  w32;
      for (int w = 0; w < 4; w++) begin
         w32 = (({l, 4'h0} + 32'(w * 4)) * 32'h9E3779B1) ^ 32'h5A5AC3C3;
         r[w*32 +: 32] = w32;
      end
      return r;
   endfunction

   // Byte-by-byte view of memory: byte b of the bundle is memory[a+b].
   function automatic logic [127:0] exp_bundle(input logic [31:0] a);
      logic [127:0] r, ln;
      logic [31:0]  ab;
      for (int b = 0; b < 16; b++) begin
         ab = a + 32'(b);
         ln = mem_line(ab[31:4]);
         r[b*8 +: 8] = ln[ab[3:0]*8 +: 8];
      end
      return r;
   endfunction

   function automatic int slot(input logic [27:0] l);
      return int'(l % 28'(LINES));
   endfunction

   function automatic bit m_has(input logic [27:0] l);
      return m_v[slot(l)] && (m_tag[slot(l)] == l);
   endfunction

   function automatic bit m_hit(input logic [31:0] a);
      logic [27:0] l0;
      l0 = a[31:4];
      return m_has(l0) && m_has(l0 + 28'd1);
   endfunction

   function automatic logic [27:0] m_first_miss(input logic [31:0] a);
      logic [27:0] l0;
      l0 = a[31:4];
      return m_has(l0) ? l0 + 28'd1 : l0;
   endfunction

   task automatic m_fill(input logic [27:0] l);
      m_v[slot(l)]   = 1'b1;
      m_tag[slot(l)] = l;
   endtask

   task automatic m_clear();
      for (int i = 0; i < LINES; i++) m_v[i] = 1'b0;
   endtask

   task automatic wait_req(input string tag, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (ftam_req.cyc) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         if (last_tid == 4'd15 && ftam_req.tid.tranid == 4'd1) saw_wrap = 1'b1;
         last_tid = ftam_req.tid.tranid;
      end
      chk({tag, "_req"}, ok, 1);
   endtask

   task automatic send_ack(input logic [3:0] t, input logic [27:0] l);
      ftam_resp            = '0;
      ftam_resp.ack        = 1'b1;
      ftam_resp.tid.core   = 6'd1;
      ftam_resp.tid.channel= 3'd2;
      ftam_resp.tid.tranid = t;
      ftam_resp.adr        = {l, 4'h0};
      ftam_resp.dat        = mem_line(l);
      @(negedge clk);
      ftam_resp = '0;
   endtask

   task automatic do_fill(input string tag);
      bit          ok;
      logic [27:0] l;
      int          lat;
      l = m_first_miss(csip_i);
      wait_req(tag, ok);
      if (ok) begin
         chk({tag, "_adr"}, ftam_req.adr, {l, 4'h0});
         chk({tag, "_tid"}, ftam_req.tid.tranid, exp_tid);
         chk({tag, "_cmd"}, {ftam_req.cmd, ftam_req.stb, ftam_req.we, ftam_req.sel},
             {CMD_LOAD, 1'b1, 1'b0, 16'hFFFF});
         lat = $urandom_range(1, 3);
         repeat (lat) @(negedge clk);
         send_ack(exp_tid, l);
         m_fill(l);
         exp_tid = nx(exp_tid);
      end
   endtask

   task automatic serve(input logic [31:0] a, input string tag);
      int g;
      csip_i = a;
      #1;
      g = 0;
      while (!m_hit(a) && g < 3) begin
         do_fill(tag);
         g++;
      end
      #1;
      chk({tag, "_hit"}, ihit_o, 1);
      chk({tag, "_bundle"}, ibundle_o, exp_bundle(a));
      chk({tag, "_busidle"}, ftam_req.cyc, 0);
   endtask

   initial begin
      bit           ok, any;
      int           c0, k;
      logic [3:0]   t;
      logic [27:0]  l;
      logic [127:0] b0, ln;
      logic [31:0]  a;

      rst_req             = '0;
      rst_req.tid.core    = 6'd1;
      rst_req.tid.channel = 3'd2;
      ftam_resp = '0;
      invall_i  = 1'b0;
      csip_i    = 32'h000F000C;
      rst_ni    = 1'b0;
      m_clear();
      exp_tid = 4'd1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_ihit", ihit_o, 0);
      chk("reset_req", ftam_req, rst_req);
      rst_ni = 1'b1;

      // Cold straddle: two fills, tranid 1 then 2
      serve(32'h000F000C, "cold");
      ln = mem_line(28'h000F000);
      chk("cold_bytesCF", ibundle_o[31:0], ln[127:96]);
      chk("cold_tid_next", exp_tid, 4'd3);

      // Aligned hit with same-cycle shift and no bus traffic
      serve(32'h000F0000, "al0");
      b0 = ibundle_o;
      csip_i = 32'h000F0004;
      #1;
      chk("al4_hit", ihit_o, 1);
      chk("al4_bundle", ibundle_o, exp_bundle(32'h000F0004));
      chk("al4_shift", ibundle_o[95:0], b0[127:32]);
      any = 1'b0;
      repeat (4) begin
         @(negedge clk);
         any = any | ftam_req.cyc;
      end
      chk("al_nobus", any, 0);

      // Retry: 8 back-off cycles, same tranid
      csip_i = 32'h00200000;
      l = 28'h0020000;
      wait_req("rty0", ok);
      c0 = cyc_cnt;
      t  = ftam_req.tid.tranid;
      chk("rty0_tid", t, exp_tid);
      @(negedge clk);
      ftam_resp            = '0;
      ftam_resp.rty        = 1'b1;
      ftam_resp.tid.tranid = t;
      @(negedge clk);
      ftam_resp = '0;
      wait_req("rty1", ok);
      chk("rty_gap", cyc_cnt - c0, 10);
      chk("rty_tid", ftam_req.tid.tranid, t);
      chk("rty_adr", ftam_req.adr, {l, 4'h0});
      @(negedge clk);
      send_ack(t, l);
      m_fill(l);
      exp_tid = nx(exp_tid);
      serve(32'h00200000, "rty_fill");

      // Wrong tid ignored, then timeout reissue with advanced tranid
      csip_i = 32'h00300008;
      l = 28'h0030000;
      wait_req("tmo0", ok);
      c0 = cyc_cnt;
      t  = ftam_req.tid.tranid;
      chk("tmo0_tid", t, exp_tid);
      @(negedge clk);
      send_ack(nx(t), l);
      chk("tmo_wrongtid_nohit", ihit_o, 0);
      wait_req("tmo1", ok);
      chk("tmo_gap", cyc_cnt - c0, TMO + 1);
      exp_tid = nx(exp_tid);
      chk("tmo_tid", ftam_req.tid.tranid, exp_tid);
      chk("tmo_adr", ftam_req.adr, {l, 4'h0});
      @(negedge clk);
      send_ack(exp_tid, l);
      m_fill(l);
      exp_tid = nx(exp_tid);
      serve(32'h00300008, "tmo_fill");

      // Invalidate mid-fill: data lands but line stays invalid
      csip_i = 32'h00400000;
      l = 28'h0040000;
      wait_req("inv0", ok);
      t = ftam_req.tid.tranid;
      @(negedge clk);
      invall_i = 1'b1;
      @(negedge clk);
      invall_i = 1'b0;
      m_clear();
      send_ack(t, l);
      exp_tid = nx(exp_tid);
      chk("inv_nohit", ihit_o, 0);
      do_fill("inv_refill");
      serve(32'h00400000, "inv_fill");
      serve(32'h000F0004, "inv_old");

      // Address wrap: line 0xFFFFFFF pairs with line 0
      serve(32'hFFFFFFF4, "wrap28");

      // Randomized fetches over two aliasing regions with occasional invall
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            @(negedge clk);
            invall_i = 1'b1;
            @(negedge clk);
            invall_i = 1'b0;
            m_clear();
         end
         a = ($urandom_range(0, 1) != 0) ? 32'h000F0000 : 32'h00010000;
         a = a | ($urandom & 32'h3FF);
         serve(a, "rnd");
      end

      // 16 consecutive fills must pass through 15 -> 1
      saw_wrap = 1'b0;
      for (int i = 0; i < 8; i++)
         serve(32'h00500000 + 32'(i * 32), "tidrun");
      chk("tid_wrap", saw_wrap, 1);

      // Async reset mid-fill; stale ack afterwards must not fill
      k = 0;
      while (exp_tid == 4'd1 && k < 4) begin
         serve(32'h00700000 + 32'(k * 32), "pre_rst");
         k++;
      end
      csip_i = 32'h00600000;
      l = 28'h0060000;
      wait_req("rst0", ok);
      t = ftam_req.tid.tranid;
      @(negedge clk);
      rst_ni = 1'b0;
      #1;
      chk("rst_ihit", ihit_o, 0);
      chk("rst_req", ftam_req, rst_req);
      @(negedge clk);
      rst_ni = 1'b1;
      m_clear();
      exp_tid  = 4'd1;
      last_tid = 4'd0;
      wait_req("rst1", ok);
      chk("rst1_adr", ftam_req.adr, {l, 4'h0});
      chk("rst1_tid", ftam_req.tid.tranid, 4'd1);
      @(negedge clk);
      send_ack(t, l);
      chk("rst_stale_nohit", ihit_o, 0);
      wait_req("rst2", ok);
      exp_tid = nx(exp_tid);
      chk("rst2_adr", ftam_req.adr, {l, 4'h0});
      chk("rst2_tid", ftam_req.tid.tranid, exp_tid);
      @(negedge clk);
      send_ack(exp_tid, l);
      m_fill(l);
      exp_tid = nx(exp_tid);
      serve(32'h00600000, "rst_fill");

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
